// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_meter
// Brief    : Measures the rising-to-rising period of a slow square wave in
//            clk_in cycles and derives the equivalent divider max value.
//            Define DUTY_MEAS_EN to also measure the high-phase duration.
// Revision : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
  parameter int WIDTH      = 32,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 100000000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] max_est,
  output logic             meas_valid,
  output logic             locked,
  output logic             no_signal,
  output logic [WIDTH-1:0] high_time
);

  localparam int                 c_MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [c_MATCH_W-1:0] c_LOCK     = c_MATCH_W'(LOCK_COUNT);
  localparam logic [WIDTH-1:0]   c_TIMEOUT_M1 = WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_s1, r_s2, r_s3;
  logic [WIDTH-1:0]     r_cnt;
  logic [c_MATCH_W-1:0] r_match_cnt;

  logic                 w_rise;
  logic                 w_timeout;
  logic [WIDTH-1:0]     w_cnt_inc;
  logic [WIDTH-1:0]     w_max_est;
  logic [c_MATCH_W-1:0] w_match_next;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_timeout = (r_state != IDLE) && !w_rise && (r_cnt == c_TIMEOUT_M1);
  assign w_cnt_inc = r_cnt + WIDTH'(1);
  // Periods below 2 cannot come from a divider; report max 0 rather than wrap.
  assign w_max_est = (w_cnt_inc < WIDTH'(2)) ? '0 : (w_cnt_inc >> 1) - WIDTH'(1);
  assign w_match_next = (r_match_cnt >= c_LOCK) ? c_LOCK : r_match_cnt + c_MATCH_W'(1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_match_cnt <= '0;
      period      <= '0;
      max_est     <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      no_signal   <= 1'b1;
    end else begin
      r_s1       <= sig_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      meas_valid <= 1'b0;
      locked     <= (r_match_cnt >= c_LOCK);

      if (w_rise || w_timeout || r_state == IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= ARMED;
          end
        end
        ARMED, TRACK: begin
          if (w_rise) begin
            r_state    <= TRACK;
            period     <= w_cnt_inc;
            max_est    <= w_max_est;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            if (r_state == TRACK && w_cnt_inc == period) begin
              r_match_cnt <= w_match_next;
            end else begin
              r_match_cnt <= c_MATCH_W'(1);
            end
          end else if (w_timeout) begin
            r_state     <= IDLE;
            period      <= '0;
            max_est     <= '0;
            r_match_cnt <= '0;
            locked      <= 1'b0;
            no_signal   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DUTY_MEAS_EN
  logic             w_fall;
  logic [WIDTH-1:0] r_hcnt;

  assign w_fall = ~r_s2 & r_s3;

  // A fall in IDLE belongs to a high phase whose start was never seen.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= '0;
      high_time <= '0;
    end else begin
      if (w_rise) begin
        r_hcnt <= '0;
      end else if (r_s2) begin
        r_hcnt <= r_hcnt + WIDTH'(1);
      end

      if (w_timeout) begin
        high_time <= '0;
      end else if (w_fall && r_state != IDLE) begin
        high_time <= r_hcnt + WIDTH'(1);
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_period_meter
// Brief    : Scoreboard bench for clock_period_meter driven by a divider-like
//            square-wave generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_period_meter;

  localparam int WIDTH      = 32;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 50;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] max_est;
  logic [WIDTH-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             no_signal;

  clock_period_meter #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
    .max_est    (max_est),
    .meas_valid (meas_valid),
    .locked     (locked),
    .no_signal  (no_signal),
    .high_time  (high_time)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned p;
    int unsigned me;
    int unsigned ht;
    logic        lk;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model of the measurement sequence
  int m_state    = 0;  // 0 idle, 1 armed, 2 tracking
  int m_last_len = 0;
  int m_last_h   = 0;
  int m_prev_p   = 0;
  int m_match    = 0;
  int last_meas_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_match = 0;
  endtask

  // One period of the slow clock: h cycles high then l cycles low.
  task automatic drive_period(input int h, input int l);
    exp_t e;
    int   p;
    @(negedge clk_in);
    sig_in = 1'b1;
    if (m_state != 0) begin
      p = m_last_len;
      if (m_state == 1)        m_match = 1;
      else if (p == m_prev_p)  m_match = (m_match >= LOCK_COUNT) ? LOCK_COUNT : m_match + 1;
      else                     m_match = 1;
      m_prev_p = p;
      e.p  = p;
      e.me = (p < 2) ? 0 : (p / 2) - 1;
`ifdef DUTY_MEAS_EN
      e.ht = m_last_h;
`else
      e.ht = 0;
`endif
      e.lk  = (m_match >= LOCK_COUNT);
      e.cyc = cyc;
      sb.push_back(e);
      m_state = 2;
    end else begin
      m_state = 1;
    end
    m_last_len = h + l;
    m_last_h   = h;
    repeat (h - 1) @(negedge clk_in);
    @(negedge clk_in);
    sig_in = 1'b0;
    repeat (l - 1) @(negedge clk_in);
  endtask

  // Output monitor: pops one expectation per measurement pulse
  initial begin
    exp_t e;
    logic lk_pend = 1'b0;
    logic lk_exp  = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (lk_pend) begin
        check("locked_next", locked, lk_exp);
        check("mv_pulse", meas_valid, 1'b0);
        lk_pend = 1'b0;
      end
      if (meas_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_meas", meas_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("period", period, e.p);
          check("max_est", max_est, e.me);
          check("high_time", high_time, e.ht);
          check("no_signal_meas", no_signal, 1'b0);
          check("meas_latency", cyc - e.cyc, 3);
          lk_pend       = 1'b1;
          lk_exp        = e.lk;
          last_meas_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ns_seen;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_period", period, 0);
    check("rst_max_est", max_est, 0);
    check("rst_meas_valid", meas_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_no_signal", no_signal, 1'b1);
    check("rst_high_time", high_time, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Divider max=4 until locked
    repeat (6) drive_period(5, 5);
    check("t1_locked", locked, 1'b1);

    // Switch to max=9, lose and regain lock
    repeat (6) drive_period(10, 10);
    check("t2_locked", locked, 1'b1);

    // Fastest measurable signal: max=0
    repeat (7) drive_period(1, 1);
    check("t3_locked", locked, 1'b1);

    // Asymmetric duty cycle
    repeat (6) drive_period(3, 7);

    // Signal stops: timeout
    ns_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in);
      #1;
      if (no_signal) begin
        ns_seen = 1'b1;
        break;
      end
    end
    check("t4_no_signal", ns_seen, 1'b1);
    check("t4_timeout_lat", cyc - last_meas_cyc, TIMEOUT);
    check("t4_locked", locked, 1'b0);
    check("t4_period", period, 0);
    check("t4_max_est", max_est, 0);
    check("t4_high_time", high_time, 0);
    model_reset();

    // Restart: first rise only arms
    repeat (3) drive_period(5, 5);
    check("t4_restart_ns", no_signal, 1'b0);

    // Reset mid-period
    drive_period(5, 5);
    @(negedge clk_in);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_period", period, 0);
    check("t5_max_est", max_est, 0);
    check("t5_locked", locked, 1'b0);
    check("t5_no_signal", no_signal, 1'b1);
    check("t5_meas_valid", meas_valid, 1'b0);
    check("t5_high_time", high_time, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
    repeat (3) drive_period(5, 5);

    repeat (10) @(negedge clk_in);
    check("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures the frequency of a slow, divider-generated square wave, counting fast-clock cycles; the inverse of the team's programmable clock divider.
- Recovers the full period, and from it the divider `max` value that would have produced it (period = 2*(max+1)).
- Flags lock after a run of identical periods and flags loss of signal on timeout.
- Sits beside the divider for self-check, or on any external slow clock input.

Parameters:
WIDTH, 32, width of cycle counter, period and max_est outputs
LOCK_COUNT, 4, consecutive identical periods needed to assert locked (>=1)
TIMEOUT, 100000000, clk_in cycles without a rising edge before declaring no signal (< 2^WIDTH)

Ports:
clk_in  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
sig_in  input  1  measured signal, asynchronous to clk_in
period  output  WIDTH  last measured rising-to-rising period in clk_in cycles
max_est  output  WIDTH  equivalent divider max: (period>>1)-1, 0 if period<2
meas_valid  output  1  one-cycle pulse when period/max_est update
locked  output  1  LOCK_COUNT consecutive equal periods seen
no_signal  output  1  high while no period is being tracked
high_time  output  WIDTH  clk_in cycles sig_in was high in last full high phase (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): sync flops 0, cnt 0, period 0, max_est 0, meas_valid 0, locked 0, no_signal 1, high_time 0, match_cnt 0, state IDLE.
- Sync: s1<=sig_in, s2<=s1, s3<=s2. rise = s2 & ~s3; fall = ~s2 & s3.
- Input edge to meas_valid latency: 3 clk_in cycles (edge sampled into s1, s2, then registered outputs update).
- cnt: cleared on any rise; otherwise +1 per cycle in ARMED/TRACK; held at 0 in IDLE.
- FSM:
  - IDLE: no_signal=1. On rise -> ARMED, cnt<=0.
  - ARMED: first edge seen, no period yet.
    - On rise -> TRACK; period<=cnt+1; max_est updated; meas_valid pulse; match_cnt<=1; no_signal<=0.
    - If cnt==TIMEOUT-1 with no rise -> IDLE.
  - TRACK, on rise:
    - period<=cnt+1; meas_valid pulse.
    - If cnt+1==old period, match_cnt<=min(match_cnt+1, LOCK_COUNT); else match_cnt<=1.
  - TRACK, timeout: if cnt==TIMEOUT-1 with no rise -> IDLE; period, max_est, match_cnt cleared; locked<=0; no_signal<=1.
- locked: registered, equals (match_cnt>=LOCK_COUNT). Drops the cycle after a mismatching period is registered. With LOCK_COUNT=1, asserts with the first measurement.
- Rise and timeout in the same cycle: rise wins (measurement taken, no timeout).
- max_est = (period>>1)-1, computed on the value being registered. Odd periods truncate. period 0 or 1 gives max_est 0.
- Minimum measurable period is 2 (sig_in toggling every cycle, divider max 0).
- Reset mid-measurement: immediate return to reset values; the first rise after release only arms.

Optional Feature:
DUTY_MEAS_EN
- Defined:
  - hcnt clears on rise and increments each cycle while s2=1.
  - On fall in ARMED/TRACK, high_time<=hcnt+1.
  - high_time is cleared with period on timeout.
  - A fall seen before the first rise after IDLE is ignored.
- Undefined: high_time tied to 0; no hcnt logic.

Test Plan:
1. Divider model with max=4 (period 10), LOCK_COUNT=4 -> after the 2nd rise: period=10, max_est=4, meas_valid one cycle. locked=1 after the 5th rise; no_signal=0 from the 2nd rise.
2. Locked at max=4, switch to max=9 -> next meas: period=20, max_est=9, locked=0 the following cycle. Relocks after 4 more equal periods (LOCK_COUNT=4).
3. max=0 (toggle every cycle) -> period=2, max_est=0, locked after LOCK_COUNT+1 rises.
4. TIMEOUT=50, stop sig_in while locked -> 50 cycles after the last rise: no_signal=1, locked=0, period=0. Restart -> first rise only arms, meas on the second.
5. Assert rst_n=0 mid-period for 1 cycle -> all outputs reset immediately; no meas_valid until two rises after release.
6. DUTY_MEAS_EN, sig_in 3 high / 7 low -> high_time=3, period=10, max_est=4. Macro undefined -> high_time stays 0.
